// File: rtl/usb_fs_in_pkt_buffer.sv
// Single-packet IN endpoint buffer for usb_fs_tx: holds one committed packet, answers IN tokens
// with DATAx/NAK/STALL, retransmits on handshake timeout and owns the data toggle.
module usb_fs_in_pkt_buffer #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_en,
    input  logic [7:0]   wr_data,
    input  logic         wr_commit,
    output logic         wr_ready,
    input  logic         stall,
    input  logic         clear_toggle,
    input  logic         in_token,
    input  logic         ack_received,
    input  logic         hs_timeout,
    output logic         pkt_start,
    output logic [3:0]   pid,
    output logic         tx_data_avail,
    input  logic         tx_data_get,
    output logic [7:0]   tx_data,
    input  logic         pkt_end,
    output logic         busy,
    output logic [2:0]   dbg_state
);

    localparam logic [3:0] PID_DATA0 = 4'b0011;
    localparam logic [3:0] PID_DATA1 = 4'b1011;
    localparam logic [3:0] PID_NAK   = 4'b1010;
    localparam logic [3:0] PID_STALL = 4'b1110;

    typedef enum logic [2:0] {
        S_FILL    = 3'd0,
        S_READY   = 3'd1,
        S_TX_DATA = 3'd2,
        S_WAIT_HS = 3'd3,
        S_TX_HS   = 3'd4
    } state_t;

    state_t        state_q, state_d;
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          toggle_q, toggle_d;
    logic          pkt_start_q, pkt_start_d;
    logic [3:0]    pid_q, pid_d;
    logic          hs_ret_q, hs_ret_d;   // 1: handshake-only reply returns to READY
    logic          mem_we;
    logic [7:0]    mem [DEPTH];

    assign wr_ready      = (state_q == S_FILL) && !wr_ptr_q[AW];
    assign tx_data_avail = (state_q == S_TX_DATA) && (rd_ptr_q != wr_ptr_q);
    assign tx_data       = mem[rd_ptr_q[AW-1:0]];
    assign busy          = (state_q != S_FILL);
    assign pkt_start     = pkt_start_q;
    assign pid           = pid_q;
    assign dbg_state     = state_q;

    // Handshake to usb_fs_tx: pkt_start is a one-cycle pulse; pid holds from pkt_start until
    // the next pkt_start; each tx_data_get pulse while tx_data_avail consumes tx_data; pkt_end
    // marks EOP sent.
    always_comb begin
        state_d     = state_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        toggle_d    = toggle_q;
        pid_d       = pid_q;
        pkt_start_d = 1'b0;
        hs_ret_d    = hs_ret_q;
        mem_we      = 1'b0;
        case (state_q)
            S_FILL: begin
                if (wr_en && wr_ready) begin
                    mem_we   = 1'b1;
                    wr_ptr_d = wr_ptr_q + 1'b1;
                end
                if (wr_commit) begin
                    state_d = S_READY;
                end else if (in_token) begin
                    pkt_start_d = 1'b1;
                    pid_d       = stall ? PID_STALL : PID_NAK;
                    hs_ret_d    = 1'b0;
                    state_d     = S_TX_HS;
                end
            end
            S_READY: begin
                if (in_token) begin
                    pkt_start_d = 1'b1;
                    if (stall) begin
                        pid_d    = PID_STALL;
                        hs_ret_d = 1'b1;
                        state_d  = S_TX_HS;
                    end else begin
                        pid_d    = toggle_q ? PID_DATA1 : PID_DATA0;
                        rd_ptr_d = '0;
                        state_d  = S_TX_DATA;
                    end
                end
            end
            S_TX_DATA: begin
                if (tx_data_get && tx_data_avail) rd_ptr_d = rd_ptr_q + 1'b1;
                if (pkt_end) state_d = S_WAIT_HS;
            end
            S_WAIT_HS: begin
                if (ack_received) begin
                    wr_ptr_d = '0;
                    rd_ptr_d = '0;
                    toggle_d = ~toggle_q;
                    state_d  = S_FILL;
                end else if (hs_timeout) begin
                    rd_ptr_d = '0;
                    state_d  = S_READY;
                end
            end
            S_TX_HS: begin
                if (pkt_end) state_d = hs_ret_q ? S_READY : S_FILL;
            end
            default: state_d = S_FILL;
        endcase
        // An explicit clear overrides a toggle flip from an ACK in the same cycle.
        if (clear_toggle) toggle_d = 1'b0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FILL;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            toggle_q    <= 1'b0;
            pkt_start_q <= 1'b0;
            pid_q       <= 4'b0000;
            hs_ret_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            toggle_q    <= toggle_d;
            pkt_start_q <= pkt_start_d;
            pid_q       <= pid_d;
            hs_ret_q    <= hs_ret_d;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule
